// File: rtl/step_sequencer.sv
// step_sequencer: self-timed step counter walking cnt 1..NUM_STEPS with DWELL cycles per step
// and a one-hot step decode; supports looping, pause and abort.
module step_sequencer #(
    parameter int NUM_STEPS = 6,
    parameter int CNT_W     = 3,
    parameter int DWELL     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 abort,
    input  logic                 loop_en,
    output logic [CNT_W-1:0]     cnt,
    output logic [NUM_STEPS-1:0] step_out,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap
);
    localparam int              TW   = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [TW-1:0]    TMAX = TW'(DWELL - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_STEPS);
    logic [TW-1:0]    tmr, tmr_n;
    logic [CNT_W-1:0] cnt_n;
    logic             done_n, wrap_n;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tmr  <= '0;
            done <= 1'b0;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_n;
            tmr  <= tmr_n;
            done <= done_n;
            wrap <= wrap_n;
        end
    end
    // cnt itself is the state: 0 = idle, nonzero = running (held while paused)
    always_comb begin
        cnt_n  = cnt;
        tmr_n  = tmr;
        done_n = 1'b0;
        wrap_n = 1'b0;
        if (cnt == '0) begin
            if (start && !abort) begin
                cnt_n = CNT_W'(1);
                tmr_n = '0;
            end
        end else if (abort) begin
            cnt_n = '0;
            tmr_n = '0;
        end else if (!pause) begin
            if (tmr == TMAX) begin
                tmr_n = '0;
                if (cnt < LAST) begin
                    cnt_n = cnt + 1'b1;
                end else if (cnt == LAST && loop_en) begin
                    cnt_n  = CNT_W'(1);
                    wrap_n = 1'b1;
                end else begin
                    // out-of-range cnt also lands here and is forced idle without done
                    cnt_n  = '0;
                    done_n = cnt == LAST;
                end
            end else begin
                tmr_n = tmr + 1'b1;
            end
        end
    end
    for (genvar i = 0; i < NUM_STEPS; i++) begin : g_dec
        assign step_out[i] = cnt == CNT_W'(i + 1);
    end
    assign busy = cnt != '0;
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed checks of step_sequencer with DWELL=2 (dut a) and DWELL=1 (dut b).
module tb_step_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       pause = 1'b0, abort = 1'b0, loop_en = 1'b0;
    logic [2:0] cnt_a, cnt_b;
    logic [5:0] step_a, step_b;
    logic       busy_a, busy_b, done_a, done_b, wrap_a, wrap_b;
    int         checks = 0;
    int         failures = 0;

    step_sequencer #(.NUM_STEPS(6), .CNT_W(3), .DWELL(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .pause(pause), .abort(abort),
        .loop_en(loop_en), .cnt(cnt_a), .step_out(step_a), .busy(busy_a),
        .done(done_a), .wrap(wrap_a)
    );

    step_sequencer #(.NUM_STEPS(6), .CNT_W(3), .DWELL(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .pause(pause), .abort(abort),
        .loop_en(loop_en), .cnt(cnt_b), .step_out(step_b), .busy(busy_b),
        .done(done_b), .wrap(wrap_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] onehot(input int c);
        logic [5:0] r;
        r = '0;
        if (c > 0) r[c-1] = 1'b1;
        return r;
    endfunction

    task automatic chk_a(input string tag, input int c, input logic d, input logic w);
        chk({tag, " cnt"}, 32'(cnt_a), 32'(c));
        chk({tag, " step"}, 32'(step_a), 32'(onehot(c)));
        chk({tag, " busy"}, 32'(busy_a), 32'(c != 0));
        chk({tag, " done"}, 32'(done_a), 32'(d));
        chk({tag, " wrap"}, 32'(wrap_a), 32'(w));
    endtask

    initial begin
        // reset state
        tick;
        chk_a("rst", 0, 1'b0, 1'b0);
        chk("rst b cnt", 32'(cnt_b), 32'd0);
        reset = 1'b0;
        tick;

        // one-shot run: cnt 1,1,2,2,..,6,6 then 0 with done on cycle 13
        start_a = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick;
            start_a = 1'b0;
            chk_a($sformatf("oneshot c%0d", i), i <= 12 ? (i + 1) / 2 : 0, i == 13, 1'b0);
        end

        // looping run: wrap on cycle 13, never done, then abort
        loop_en = 1'b1;
        start_a = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick;
            start_a = 1'b0;
            chk_a($sformatf("loop c%0d", i), ((i - 1) % 12) / 2 + 1, 1'b0, i == 13);
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        loop_en = 1'b0;
        chk_a("loop abort", 0, 1'b0, 1'b0);

        // pause for 5 cycles at cnt=3 timer=1
        start_a = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick;
            start_a = 1'b0;
        end
        chk_a("pre-pause", 3, 1'b0, 1'b0);
        pause = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick;
            chk_a($sformatf("pause p%0d", i), 3, 1'b0, 1'b0);
        end
        pause = 1'b0;
        tick;
        chk_a("unpause", 4, 1'b0, 1'b0);
        tick;
        tick;
        chk_a("pre-abort", 5, 1'b0, 1'b0);

        // abort with pause and start at cnt=5; then start+abort in idle
        pause = 1'b1;
        start_a = 1'b1;
        abort = 1'b1;
        tick;
        chk_a("abort run", 0, 1'b0, 1'b0);
        tick;
        chk_a("abort idle", 0, 1'b0, 1'b0);
        pause = 1'b0;
        start_a = 1'b0;
        abort = 1'b0;
        tick;
        chk_a("after abort", 0, 1'b0, 1'b0);

        // async reset mid-run at cnt=4
        start_a = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick;
            start_a = 1'b0;
        end
        chk_a("pre-reset", 4, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_a("reset async", 0, 1'b0, 1'b0);
        tick;
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick;
            chk_a($sformatf("post-reset c%0d", i), 0, 1'b0, 1'b0);
        end

        // DWELL=1: one step per cycle, restart attempt at cnt=2 ignored
        start_b = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick;
            start_b = (i == 2);
            chk($sformatf("d1 cnt c%0d", i), 32'(cnt_b), 32'(i <= 6 ? i : 0));
            chk($sformatf("d1 step c%0d", i), 32'(step_b), 32'(onehot(i <= 6 ? i : 0)));
            chk($sformatf("d1 busy c%0d", i), 32'(busy_b), 32'(i <= 6));
            chk($sformatf("d1 done c%0d", i), 32'(done_b), 32'(i == 7));
            chk($sformatf("d1 wrap c%0d", i), 32'(wrap_b), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
